multi_digit_display: RTL and testbench

Parametrised multiplexed 7-segment display driver for score, combo and timer readouts. Accepts a binary value via a load strobe, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes NUM_DIGITS digits onto a shared segment bus. It adds leading-zero blanking, overflow indication, an anti-ghosting blank interval and selectable output polarities. It sits between game-state logic and the board's digit transistors and segment cathodes.

---
 rtl/display_pkg.sv | 52 +++++
 rtl/bin2bcd_seq.sv | 130 +++++++++++++
 rtl/multi_digit_display.sv | 127 ++++++++++++
 tb/tb_multi_digit_display.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared glyph constants, BCD-to-segment lookup and converter state type for
// the multiplexed 7-segment display driver.
package display_pkg;

  // Glyphs are stored active-low in {g,f,e,d,c,b,a} order.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] result;
    result = 64'd1;
    for (int i = 0; i < n; i++) begin
      result = result * 64'd10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; the visible BCD value and
// overflow flag change only on the commit cycle.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VALUE_W    = 9,
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  output logic                    busy,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] disp_bcd
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(VALUE_W - 1);
  localparam logic [63:0]   OVF_LIMIT  = pow10(NUM_DIGITS);

  conv_state_t       state_r;
  conv_state_t       state_nxt_s;
  logic              capture_s;
  logic              shift_s;
  logic              commit_s;
  logic [VALUE_W-1:0] bin_r;
  logic [BW-1:0]     bcd_r;
  logic [BW-1:0]     adj_s;
  logic [CW-1:0]     cnt_r;
  logic              ovf_pend_r;
  logic              busy_r;
  logic              overflow_r;
  logic [BW-1:0]     disp_bcd_r;

  // Converter state register and registered busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CONV_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != CONV_IDLE);
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    shift_s     = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      CONV_IDLE: begin
        if (load) begin
          capture_s   = 1'b1;
          state_nxt_s = CONV_SHIFT;
        end else begin
          state_nxt_s = CONV_IDLE;
        end
      end
      CONV_SHIFT: begin
        shift_s = 1'b1;
        if (cnt_r == LAST_SHIFT) begin
          state_nxt_s = CONV_COMMIT;
        end else begin
          state_nxt_s = CONV_SHIFT;
        end
      end
      CONV_COMMIT: begin
        commit_s    = 1'b1;
        state_nxt_s = CONV_IDLE;
      end
      default: begin
        state_nxt_s = CONV_IDLE;
      end
    endcase
  end

  // Add-3 correction applied to every working nibble before the shift.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) begin
        adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      end else begin
        adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
      end
    end
  end

  // Working shift register; the carry out of the top nibble is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_r      <= '0;
      bcd_r      <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= 1'b0;
    end else if (capture_s) begin
      bin_r      <= value;
      bcd_r      <= '0;
      cnt_r      <= '0;
      ovf_pend_r <= (64'(value) >= OVF_LIMIT);
    end else if (shift_s) begin
      {bcd_r, bin_r} <= {adj_s[BW-2:0], bin_r, 1'b0};
      cnt_r          <= cnt_r + CW'(1);
    end else begin
      bin_r <= bin_r;
    end
  end

  // Displayed value and overflow flag, updated only on commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_bcd_r <= '0;
      overflow_r <= 1'b0;
    end else if (commit_s) begin
      disp_bcd_r <= bcd_r;
      overflow_r <= ovf_pend_r;
    end else begin
      disp_bcd_r <= disp_bcd_r;
    end
  end

  assign busy     = busy_r;
  assign overflow = overflow_r;
  assign disp_bcd = disp_bcd_r;

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed 7-segment driver: converts a loaded binary value to BCD and
// scans the digits with a blanking gap at the start of every dwell.
module multi_digit_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS       = 2,
  parameter int VALUE_W          = 9,
  parameter int DWELL_CYCLES     = 32768,
  parameter int BLANK_CYCLES     = 64,
  parameter int BLANK_LEADING    = 1,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [6:0]            seg
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF =
    (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] disp_bcd_s;
  logic                    overflow_s;
  logic [DW-1:0]           dwell_cnt_r;
  logic [SW-1:0]           scan_idx_r;
  logic [3:0]              nibble_s;
  logic                    upper_zero_s;
  logic [6:0]              glyph_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [6:0]              seg_r;
  logic [NUM_DIGITS-1:0]   digit_en_r;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow_s),
    .disp_bcd (disp_bcd_s)
  );

  // Dwell timer and scanned digit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt_r <= '0;
      scan_idx_r  <= '0;
    end else if (dwell_cnt_r == DWELL_LAST) begin
      dwell_cnt_r <= '0;
      if (scan_idx_r == SCAN_LAST) begin
        scan_idx_r <= '0;
      end else begin
        scan_idx_r <= scan_idx_r + SW'(1);
      end
    end else begin
      dwell_cnt_r <= dwell_cnt_r + DW'(1);
    end
  end

  // Glyph for the scanned digit, including dash and leading-zero blanking.
  always_comb begin
    nibble_s     = 4'd0;
    upper_zero_s = 1'b1;
    glyph_s      = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == int'(scan_idx_r)) begin
        nibble_s = disp_bcd_s[i*4 +: 4];
      end else begin
        nibble_s = nibble_s;
      end
      if ((i >= int'(scan_idx_r)) && (disp_bcd_s[i*4 +: 4] != 4'd0)) begin
        upper_zero_s = 1'b0;
      end else begin
        upper_zero_s = upper_zero_s;
      end
    end
    if (overflow_s) begin
      glyph_s = SEG_DASH;
    end else if ((BLANK_LEADING != 0) && (scan_idx_r != SW'(0)) && upper_zero_s) begin
      glyph_s = SEG_BLANK;
    end else begin
      glyph_s = bcd_to_seg(nibble_s);
    end
  end

  // One-hot digit select, suppressed during the anti-ghosting gap.
  always_comb begin
    sel_s = {NUM_DIGITS{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i == int'(scan_idx_r)) && (dwell_cnt_r >= BLANK_END)) begin
        sel_s[i] = 1'b1;
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Output registers; board polarity is applied only here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r      <= SEG_OFF;
      digit_en_r <= DIGIT_OFF;
    end else begin
      seg_r      <= (SEG_ACTIVE_LOW != 0) ? glyph_s : ~glyph_s;
      digit_en_r <= (DIGIT_ACTIVE_LOW != 0) ? ~sel_s : sel_s;
    end
  end

  assign overflow = overflow_s;
  assign seg      = seg_r;
  assign digit_en = digit_en_r;

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench: table of display vectors, hand sequences for busy and
// reset corners, and random loads checked against a behavioural model.
module tb_multi_digit_display;

  localparam int ND    = 2;
  localparam int VW    = 9;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [VW-1:0] value = '0;
  logic          busy;
  logic          overflow;
  logic [ND-1:0] digit_en;
  logic [6:0]    seg;

  int vectors = 0;
  int miscompares = 0;

  // Model: edges since reset, shown value, pending value, busy cycles left.
  int m_edges;
  int m_disp;
  int m_pending;
  int m_left;

  typedef struct {
    int         v;
    logic [6:0] d0;
    logic [6:0] d1;
    logic       ovf;
  } vec_t;

  vec_t tbl[6];

  multi_digit_display #(
    .NUM_DIGITS   (ND),
    .VALUE_W      (VW),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .digit_en (digit_en),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input int idx, input int v);
    if (v >= 100) return 7'b0111111;
    if (idx == 0) return ref_glyph(v % 10);
    if (v < 10) return 7'b1111111;
    return ref_glyph(v / 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges   = 0;
    m_disp    = 0;
    m_pending = 0;
    m_left    = 0;
  endtask

  task automatic tick();
    logic [6:0] e_seg;
    logic [1:0] e_den;
    int pos;
    int idx;
    @(posedge clk);
    pos   = m_edges % DWELL;
    idx   = (m_edges / DWELL) % ND;
    e_seg = ref_seg(idx, m_disp);
    e_den = (pos < BLANK) ? 2'b11 : ~(2'b01 << idx);
    m_edges++;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_disp = m_pending;
    end else if (load) begin
      m_pending = int'(value);
      m_left    = VW + 1;
    end
    #1;
    check("busy", 32'(busy), 32'(m_left > 0));
    check("overflow", 32'(overflow), 32'(m_disp >= 100));
    check("digit_en", 32'(digit_en), 32'(e_den));
    check("seg", 32'(seg), 32'(e_seg));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v);
    value = VW'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_display(input string name, input logic [6:0] d0,
                               input logic [6:0] d1, input logic ovf);
    bit seen0;
    bit seen1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < 40 && !(seen0 && seen1); i++) begin
      tick();
      if (digit_en == 2'b10 && !seen0) begin
        seen0 = 1'b1;
        check({name, "_d0"}, 32'(seg), 32'(d0));
      end else if (digit_en == 2'b01 && !seen1) begin
        seen1 = 1'b1;
        check({name, "_d1"}, 32'(seg), 32'(d1));
      end else begin
        seen0 = seen0;
      end
    end
    check({name, "_ovf"}, 32'(overflow), 32'(ovf));
    check({name, "_scan_seen"}, {30'd0, seen1, seen0}, 32'd3);
  endtask

  task automatic hit_reset(input string name);
    reset = 1'b0;
    #1;
    check({name, "_den"}, 32'(digit_en), 32'h3);
    check({name, "_seg"}, 32'(seg), 32'h7f);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_ovf"}, 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int bcnt;
    tbl[0] = '{v: 42,  d0: 7'b0100100, d1: 7'b0011001, ovf: 1'b0};
    tbl[1] = '{v: 7,   d0: 7'b1111000, d1: 7'b1111111, ovf: 1'b0};
    tbl[2] = '{v: 0,   d0: 7'b1000000, d1: 7'b1111111, ovf: 1'b0};
    tbl[3] = '{v: 100, d0: 7'b0111111, d1: 7'b0111111, ovf: 1'b1};
    tbl[4] = '{v: 511, d0: 7'b0111111, d1: 7'b0111111, ovf: 1'b1};
    tbl[5] = '{v: 99,  d0: 7'b0011000, d1: 7'b0011000, ovf: 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_den", 32'(digit_en), 32'h3);
    check("por_seg", 32'(seg), 32'h7f);
    reset = 1'b1;
    run(20);

    // Busy length for a single conversion.
    do_load(42);
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 30 && busy; i++) begin
      tick();
      if (busy) bcnt++;
    end
    check("busy_len", 32'(bcnt), 32'd10);

    for (int t = 0; t < 6; t++) begin
      do_load(tbl[t].v);
      wait_idle();
      check_display($sformatf("tbl%0d", tbl[t].v), tbl[t].d0, tbl[t].d1, tbl[t].ovf);
    end

    // Load during shift is ignored.
    do_load(55);
    run(2);
    value = VW'(33);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    wait_idle();
    check_display("ign55", 7'b0010010, 7'b0010010, 1'b0);

    // Load on the commit cycle is ignored.
    do_load(42);
    run(9);
    value = VW'(7);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    check("commit_ign_busy", 32'(busy), 32'd0);
    check_display("commit42", 7'b0100100, 7'b0011001, 1'b0);

    // Reset mid-shift, then a clean load.
    do_load(77);
    run(4);
    hit_reset("rst_mid");
    do_load(12);
    wait_idle();
    check_display("after_rst12", 7'b0100100, 7'b1111001, 1'b0);

    // Scan over 64 cycles with one-hot select outside the gap.
    for (int i = 0; i < 64; i++) begin
      tick();
      if (digit_en != 2'b11) check("onehot", 32'($countones(~digit_en)), 32'd1);
    end

    // Random loads, including ones that land while busy.
    for (int i = 0; i < 400; i++) begin
      value = VW'($urandom_range(0, 511));
      load  = ($urandom_range(0, 5) == 0);
      tick();
    end
    load = 1'b0;
    wait_idle();
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
